// File: rtl/lattice_neighbor_scan.sv
// Raster-order frame scanner that emits, per cell, the BRAM address of every lattice neighbour.
// Edges wrap (periodic) or clamp to the centre with a wall flag; valid/ready output with a global stall.
module lattice_neighbor_scan #(
  parameter int unsigned HPIXELS = 205,
  parameter int unsigned VPIXELS = 154,
  parameter int unsigned NDIRS   = 9,
  parameter int unsigned LATENCY = 3,
  localparam int unsigned HOR_SIZE  = (HPIXELS > 1) ? $clog2(HPIXELS) : 1,
  localparam int unsigned VERT_SIZE = (VPIXELS > 1) ? $clog2(VPIXELS) : 1,
  localparam int unsigned BRAM_SIZE = (HPIXELS * VPIXELS > 1) ? $clog2(HPIXELS * VPIXELS) : 1
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               start_in,
  input  logic                               mode_in,
  input  logic                               ready_in,
  output logic                               valid_out,
  output logic [NDIRS-1:0][BRAM_SIZE-1:0]    addr_out,
  output logic [NDIRS-1:0]                   wall_out,
  output logic [HOR_SIZE-1:0]                hor_out,
  output logic [VERT_SIZE-1:0]               vert_out,
  output logic                               last_out,
  output logic                               busy_out,
  output logic                               done_out
);

  localparam logic [HOR_SIZE-1:0]  HMAX = HOR_SIZE'(HPIXELS - 1);
  localparam logic [VERT_SIZE-1:0] VMAX = VERT_SIZE'(VPIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  state_t                             r_state;
  logic                               r_mode;
  logic [HOR_SIZE-1:0]                r_hor;
  logic [VERT_SIZE-1:0]               r_vert;
  logic [LATENCY-1:0]                 r_pvld;
  logic [LATENCY-1:0]                 r_plast;
  logic [LATENCY-1:0][HOR_SIZE-1:0]   r_phor;
  logic [LATENCY-1:0][VERT_SIZE-1:0]  r_pvert;

  logic                               w_adv;
  logic                               w_issue;
  logic                               w_cell_last;
  logic                               w_hs_last;
  logic [NDIRS-1:0][BRAM_SIZE-1:0]    w_addr;
  logic [NDIRS-1:0]                   w_wall;

  // Direction order: D2Q9 C,N,NE,E,SE,S,SW,W,NW; D2Q5 C,N,E,S,W. N is row-1, E is col+1.
  function automatic int dir_dx(input int d);
    if (NDIRS == 9) begin
      case (d)
        2, 3, 4: return 1;
        6, 7, 8: return -1;
        default: return 0;
      endcase
    end
    case (d)
      2:       return 1;
      4:       return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dir_dy(input int d);
    if (NDIRS == 9) begin
      case (d)
        1, 2, 8: return -1;
        4, 5, 6: return 1;
        default: return 0;
      endcase
    end
    case (d)
      1:       return -1;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [BRAM_SIZE-1:0] cell_addr(input logic [HOR_SIZE-1:0] h,
                                                     input logic [VERT_SIZE-1:0] v);
    return BRAM_SIZE'(v) * BRAM_SIZE'(HPIXELS) + BRAM_SIZE'(h);
  endfunction

  // Returns {wall, address} for one direction of cell (h, v).
  function automatic logic [BRAM_SIZE:0] neighbour(input logic [HOR_SIZE-1:0] h,
                                                   input logic [VERT_SIZE-1:0] v,
                                                   input logic clamp,
                                                   input int d);
    logic [HOR_SIZE-1:0]  nh;
    logic [VERT_SIZE-1:0] nv;
    logic                 off;
    int                   dx;
    int                   dy;
    dx  = dir_dx(d);
    dy  = dir_dy(d);
    nh  = h;
    nv  = v;
    off = 1'b0;
    if (dx > 0) begin
      if (h == HMAX) begin nh = '0; off = 1'b1; end
      else nh = h + HOR_SIZE'(1);
    end else if (dx < 0) begin
      if (h == '0) begin nh = HMAX; off = 1'b1; end
      else nh = h - HOR_SIZE'(1);
    end
    if (dy > 0) begin
      if (v == VMAX) begin nv = '0; off = 1'b1; end
      else nv = v + VERT_SIZE'(1);
    end else if (dy < 0) begin
      if (v == '0) begin nv = VMAX; off = 1'b1; end
      else nv = v - VERT_SIZE'(1);
    end
    if (clamp && off) return {1'b1, cell_addr(h, v)};
    return {1'b0, cell_addr(nh, nv)};
  endfunction

  assign w_adv       = ready_in | ~valid_out;
  assign w_issue     = (r_state == S_SCAN);
  assign w_cell_last = (r_hor == HMAX) && (r_vert == VMAX);
  assign w_hs_last   = valid_out & ready_in & last_out;

  // Frame control: mode is captured at start and held for the whole frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= S_IDLE;
      r_mode   <= 1'b0;
      r_hor    <= '0;
      r_vert   <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_state  <= S_SCAN;
            r_mode   <= mode_in;
            r_hor    <= '0;
            r_vert   <= '0;
            busy_out <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_adv) begin
            if (w_cell_last) begin
              r_state <= S_DRAIN;
            end else if (r_hor == HMAX) begin
              r_hor  <= '0;
              r_vert <= r_vert + VERT_SIZE'(1);
            end else begin
              r_hor <= r_hor + HOR_SIZE'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_hs_last) begin
            r_state  <= S_IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Cell pipeline; every stage moves only when the output can advance.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pvld  <= '0;
      r_plast <= '0;
      r_phor  <= '0;
      r_pvert <= '0;
    end else if (w_adv) begin
      r_pvld[0]  <= w_issue;
      r_plast[0] <= w_issue & w_cell_last;
      r_phor[0]  <= r_hor;
      r_pvert[0] <= r_vert;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_pvld[i]  <= r_pvld[i-1];
        r_plast[i] <= r_plast[i-1];
        r_phor[i]  <= r_phor[i-1];
        r_pvert[i] <= r_pvert[i-1];
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_wall = '0;
    for (int d = 0; d < int'(NDIRS); d++) begin
      {w_wall[d], w_addr[d]} = neighbour(r_phor[LATENCY-1], r_pvert[LATENCY-1], r_mode, d);
    end
  end

  // Output beat register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      hor_out   <= '0;
      vert_out  <= '0;
      addr_out  <= '0;
      wall_out  <= '0;
    end else if (w_adv) begin
      valid_out <= r_pvld[LATENCY-1];
      last_out  <= r_plast[LATENCY-1];
      hor_out   <= r_phor[LATENCY-1];
      vert_out  <= r_pvert[LATENCY-1];
      addr_out  <= w_addr;
      wall_out  <= w_wall;
    end
  end

endmodule

// File: tb/tb_lattice_neighbor_scan.sv
// Bench for lattice_neighbor_scan: default D2Q9 grid plus a 4x3 D2Q5 instance,
// each beat compared against an arithmetic neighbour model, plus a table of hand-derived probes.
module tb_lattice_neighbor_scan;

  logic clk;
  logic rst_n;

  logic              b_start, b_mode, b_ready;
  logic              b_valid, b_last, b_busy, b_done;
  logic [8:0][14:0]  b_addr;
  logic [8:0]        b_wall;
  logic [7:0]        b_hor, b_vert;

  logic              s_start, s_mode, s_ready;
  logic              s_valid, s_last, s_busy, s_done;
  logic [4:0][3:0]   s_addr;
  logic [4:0]        s_wall;
  logic [1:0]        s_hor, s_vert;

  lattice_neighbor_scan #(.HPIXELS(205), .VPIXELS(154), .NDIRS(9), .LATENCY(3)) u_big (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(b_start), .mode_in(b_mode), .ready_in(b_ready),
    .valid_out(b_valid), .addr_out(b_addr), .wall_out(b_wall), .hor_out(b_hor),
    .vert_out(b_vert), .last_out(b_last), .busy_out(b_busy), .done_out(b_done)
  );

  lattice_neighbor_scan #(.HPIXELS(4), .VPIXELS(3), .NDIRS(5), .LATENCY(1)) u_small (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(s_start), .mode_in(s_mode), .ready_in(s_ready),
    .valid_out(s_valid), .addr_out(s_addr), .wall_out(s_wall), .hor_out(s_hor),
    .vert_out(s_vert), .last_out(s_last), .busy_out(s_busy), .done_out(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int u; bit m; int h; int v; int d; int ea; bit ew;
    int ga; bit gw; bit seen;
  } probe_t;

  probe_t       tab[$];
  int           checks, errors, cyc;
  int           idx[2], done_cnt[2], start_cyc[2], last_hs_cyc[2];
  bit           mode_l[2], first_pending[2], prev_stall[2], rnd[2], jitter[2];
  logic [255:0] snap[2];

  function automatic int uh(input int u);   return (u == 0) ? 205 : 4; endfunction
  function automatic int uv(input int u);   return (u == 0) ? 154 : 3; endfunction
  function automatic int un(input int u);   return (u == 0) ? 9 : 5;   endfunction
  function automatic int ul(input int u);   return (u == 0) ? 3 : 1;   endfunction
  function automatic int utot(input int u); return uh(u) * uv(u);      endfunction

  // Neighbour rule from the grid definition: offset, then wrap with modulo or clamp to centre.
  function automatic void ref_cell(input int u, input int h, input int v, input bit m,
                                   output int ea[9], output bit ew[9]);
    int dx9[9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
    int dy9[9] = '{0, -1, -1, 0, 1, 1, 1, 0, -1};
    int dx5[9] = '{0, 0, 1, 0, -1, 0, 0, 0, 0};
    int dy5[9] = '{0, -1, 0, 1, 0, 0, 0, 0, 0};
    int hh, vv, nh, nv;
    bit off;
    hh = uh(u);
    vv = uv(u);
    for (int d = 0; d < 9; d++) begin
      ea[d] = 0;
      ew[d] = 1'b0;
      if (d < un(u)) begin
        nh  = h + ((un(u) == 9) ? dx9[d] : dx5[d]);
        nv  = v + ((un(u) == 9) ? dy9[d] : dy5[d]);
        off = (nh < 0) || (nh >= hh) || (nv < 0) || (nv >= vv);
        if (m && off) begin
          ea[d] = v * hh + h;
          ew[d] = 1'b1;
        end else begin
          ea[d] = ((nv + vv) % vv) * hh + ((nh + hh) % hh);
        end
      end
    end
  endfunction

  function automatic void add_probe(input int u, input bit m, input int h, input int v,
                                    input int d, input int ea, input bit ew);
    probe_t p;
    p.u = u; p.m = m; p.h = h; p.v = v; p.d = d; p.ea = ea; p.ew = ew;
    p.ga = -1; p.gw = 1'b0; p.seen = 1'b0;
    tab.push_back(p);
  endfunction

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic mon_unit(input int u, input logic valid, input logic rdy, input logic done,
                          input logic busy, input logic last, input int hor, input int vert,
                          input int a[9], input bit w[9], input logic [255:0] cur);
    int eh, ev, bd;
    int ea[9];
    bit ew[9];
    bit ok;
    if (prev_stall[u])
      chk(cur == snap[u], "stall_hold", $sformatf("u%0d got %h want %h", u, cur, snap[u]));
    if (first_pending[u] && valid) begin
      chk(cyc == start_cyc[u] + 1 + ul(u), "first_valid_latency",
          $sformatf("u%0d got edge %0d want %0d", u, cyc - start_cyc[u], 1 + ul(u)));
      first_pending[u] = 1'b0;
    end
    if (valid && rdy) begin
      eh = idx[u] % uh(u);
      ev = idx[u] / uh(u);
      ref_cell(u, eh, ev, mode_l[u], ea, ew);
      ok = (idx[u] < utot(u)) && (hor == eh) && (vert == ev) && (last == (idx[u] == utot(u) - 1));
      bd = -1;
      for (int d = 0; d < 9; d++)
        if (a[d] != ea[d] || w[d] != ew[d]) begin
          ok = 1'b0;
          if (bd < 0) bd = d;
        end
      if (bd < 0) bd = 0;
      chk(ok, "beat", $sformatf("u%0d n%0d got (%0d,%0d) last %0d d%0d addr %0d wall %0d; want (%0d,%0d) addr %0d wall %0d",
          u, idx[u], hor, vert, last, bd, a[bd], w[bd], eh, ev, ea[bd], ew[bd]));
      for (int k = 0; k < tab.size(); k++)
        if (tab[k].u == u && tab[k].m == mode_l[u] && tab[k].h == hor && tab[k].v == vert) begin
          tab[k].ga   = a[tab[k].d];
          tab[k].gw   = w[tab[k].d];
          tab[k].seen = 1'b1;
        end
      if (idx[u] == utot(u) - 1) last_hs_cyc[u] = cyc;
      idx[u]++;
    end
    if (done) begin
      done_cnt[u]++;
      chk(idx[u] == utot(u) && cyc == last_hs_cyc[u] + 1 && !busy, "done_timing",
          $sformatf("u%0d got beats %0d gap %0d busy %0d want %0d 1 0",
          u, idx[u], cyc - last_hs_cyc[u], busy, utot(u)));
    end
    prev_stall[u] = valid && !rdy;
    snap[u]       = cur;
  endtask

  task automatic monitor();
    int a[9];
    bit w[9];
    for (int d = 0; d < 9; d++) begin a[d] = int'(b_addr[d]); w[d] = b_wall[d]; end
    mon_unit(0, b_valid, b_ready, b_done, b_busy, b_last, int'(b_hor), int'(b_vert), a, w,
             256'({b_valid, b_last, b_hor, b_vert, b_wall, b_addr}));
    for (int d = 0; d < 9; d++) begin a[d] = 0; w[d] = 1'b0; end
    for (int d = 0; d < 5; d++) begin a[d] = int'(s_addr[d]); w[d] = s_wall[d]; end
    mon_unit(1, s_valid, s_ready, s_done, s_busy, s_last, int'(s_hor), int'(s_vert), a, w,
             256'({s_valid, s_last, s_hor, s_vert, s_wall, s_addr}));
  endtask

  // One clock: drive after the rising edge, observe on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    b_ready = rnd[0] ? 1'($urandom_range(0, 1)) : 1'b1;
    s_ready = rnd[1] ? 1'($urandom_range(0, 1)) : 1'b1;
    if (jitter[0]) b_mode = 1'($urandom_range(0, 1));
    if (jitter[1]) s_mode = 1'($urandom_range(0, 1));
    @(negedge clk);
    monitor();
  endtask

  task automatic start_frame(input int u, input bit m);
    if (u == 0) begin b_mode = m; b_start = 1'b1; end
    else        begin s_mode = m; s_start = 1'b1; end
    mode_l[u]        = m;
    idx[u]           = 0;
    done_cnt[u]      = 0;
    first_pending[u] = 1'b1;
    tick();
    start_cyc[u] = cyc;
    b_start = 1'b0;
    s_start = 1'b0;
    chk(((u == 0) ? b_busy : s_busy) == 1'b1, "busy_rise", $sformatf("u%0d got 0 want 1", u));
  endtask

  task automatic run_frame(input int u, input bit m, input bit r, input int budget);
    rnd[u] = r;
    start_frame(u, m);
    for (int k = 0; k < budget && done_cnt[u] == 0; k++) tick();
    chk(done_cnt[u] == 1, "frame_done", $sformatf("u%0d got %0d done pulses want 1", u, done_cnt[u]));
    chk(idx[u] == utot(u), "beat_count", $sformatf("u%0d got %0d want %0d", u, idx[u], utot(u)));
    tick();
    tick();
    chk(done_cnt[u] == 1 && ((u == 0) ? b_busy : s_busy) == 1'b0, "idle_after",
        $sformatf("u%0d got done %0d busy %0d want 1 0", u, done_cnt[u], (u == 0) ? b_busy : s_busy));
    if (!r)
      chk(last_hs_cyc[u] == start_cyc[u] + ul(u) + utot(u), "throughput",
          $sformatf("u%0d got last beat at %0d want %0d", u, last_hs_cyc[u] - start_cyc[u], ul(u) + utot(u)));
    rnd[u] = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0;
    b_start = 1'b0; b_mode = 1'b0; b_ready = 1'b1;
    s_start = 1'b0; s_mode = 1'b0; s_ready = 1'b1;
    for (int u = 0; u < 2; u++) begin
      idx[u] = 0; done_cnt[u] = 0; start_cyc[u] = 0; last_hs_cyc[u] = 0;
      mode_l[u] = 1'b0; first_pending[u] = 1'b0; prev_stall[u] = 1'b0;
      rnd[u] = 1'b0; jitter[u] = 1'b0; snap[u] = '0;
    end

    // Hand-derived probes: {unit, mode, col, row, dir, address, wall}.
    add_probe(0, 0, 0, 0, 0, 0, 0);       add_probe(0, 0, 0, 0, 1, 31365, 0);
    add_probe(0, 0, 0, 0, 2, 31366, 0);   add_probe(0, 0, 0, 0, 3, 1, 0);
    add_probe(0, 0, 0, 0, 4, 206, 0);     add_probe(0, 0, 0, 0, 5, 205, 0);
    add_probe(0, 0, 0, 0, 6, 409, 0);     add_probe(0, 0, 0, 0, 7, 204, 0);
    add_probe(0, 0, 0, 0, 8, 31569, 0);
    add_probe(0, 0, 204, 153, 0, 31569, 0); add_probe(0, 0, 204, 153, 1, 31364, 0);
    add_probe(0, 0, 204, 153, 3, 31365, 0); add_probe(0, 0, 204, 153, 4, 0, 0);
    add_probe(0, 0, 204, 153, 5, 204, 0);   add_probe(0, 0, 204, 153, 7, 31568, 0);
    add_probe(0, 1, 0, 0, 0, 0, 0);       add_probe(0, 1, 0, 0, 1, 0, 1);
    add_probe(0, 1, 0, 0, 2, 0, 1);       add_probe(0, 1, 0, 0, 3, 1, 0);
    add_probe(0, 1, 0, 0, 4, 206, 0);     add_probe(0, 1, 0, 0, 5, 205, 0);
    add_probe(0, 1, 0, 0, 6, 0, 1);       add_probe(0, 1, 0, 0, 7, 0, 1);
    add_probe(0, 1, 0, 0, 8, 0, 1);
    add_probe(0, 1, 10, 10, 0, 2060, 0);  add_probe(0, 1, 10, 10, 3, 2061, 0);
    add_probe(0, 1, 10, 10, 1, 1855, 0);  add_probe(0, 1, 10, 10, 8, 1854, 0);
    add_probe(0, 1, 204, 153, 3, 31569, 1); add_probe(0, 1, 204, 153, 5, 31569, 1);
    add_probe(0, 1, 204, 153, 7, 31568, 0); add_probe(0, 1, 204, 153, 1, 31364, 0);
    add_probe(1, 0, 0, 0, 0, 0, 0);       add_probe(1, 0, 0, 0, 1, 8, 0);
    add_probe(1, 0, 0, 0, 2, 1, 0);       add_probe(1, 0, 0, 0, 3, 4, 0);
    add_probe(1, 0, 0, 0, 4, 3, 0);
    add_probe(1, 1, 3, 2, 2, 11, 1);      add_probe(1, 1, 3, 2, 3, 11, 1);
    add_probe(1, 1, 3, 2, 4, 10, 0);      add_probe(1, 1, 3, 2, 1, 7, 0);

    tick();
    tick();
    chk({b_valid, b_addr, b_wall, b_hor, b_vert, b_last, b_busy, b_done} == '0, "reset_big",
        $sformatf("got valid %0d busy %0d addr0 %0d want all 0", b_valid, b_busy, b_addr[0]));
    chk({s_valid, s_addr, s_wall, s_hor, s_vert, s_last, s_busy, s_done} == '0, "reset_small",
        $sformatf("got valid %0d busy %0d want all 0", s_valid, s_busy));
    #1 rst_n = 1'b1;
    tick();

    // Small D2Q5 grid: periodic and clamp, then random modes under random back-pressure.
    run_frame(1, 1'b0, 1'b0, 200);
    run_frame(1, 1'b1, 1'b1, 400);
    jitter[1] = 1'b1;
    for (int f = 0; f < 4; f++) run_frame(1, 1'($urandom_range(0, 1)), 1'b1, 400);
    jitter[1] = 1'b0;

    // Full default frames, ready held high.
    run_frame(0, 1'b0, 1'b0, 32000);
    run_frame(0, 1'b1, 1'b0, 32000);

    // Back-pressure with mode noise, an ignored start pulse, then an asynchronous abort.
    rnd[0] = 1'b1;
    start_frame(0, 1'b0);
    jitter[0] = 1'b1;
    for (int k = 0; k < 1500; k++) tick();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk(b_busy == 1'b1 && done_cnt[0] == 0, "start_ignored",
        $sformatf("got busy %0d done %0d want 1 0", b_busy, done_cnt[0]));
    for (int k = 0; k < 500; k++) tick();
    chk(idx[0] > 500 && idx[0] < 2000, "stall_progress",
        $sformatf("got %0d beats want between 500 and 2000", idx[0]));
    #1 rst_n = 1'b0;
    #1;
    chk({b_valid, b_addr, b_wall, b_hor, b_vert, b_last, b_busy, b_done} == '0, "async_reset_big",
        $sformatf("got valid %0d busy %0d hor %0d want all 0", b_valid, b_busy, b_hor));
    chk({s_valid, s_addr, s_wall, s_hor, s_vert, s_last, s_busy, s_done} == '0, "async_reset_small",
        $sformatf("got valid %0d busy %0d want all 0", s_valid, s_busy));
    #1 rst_n = 1'b1;
    rnd[0] = 1'b0;
    jitter[0] = 1'b0;
    b_mode = 1'b0;
    for (int u = 0; u < 2; u++) begin
      prev_stall[u] = 1'b0; first_pending[u] = 1'b0; done_cnt[u] = 0;
    end
    for (int k = 0; k < 10; k++) tick();
    chk(done_cnt[0] == 0 && b_busy == 1'b0 && b_valid == 1'b0, "no_done_after_abort",
        $sformatf("got done %0d busy %0d valid %0d want 0 0 0", done_cnt[0], b_busy, b_valid));
    start_frame(0, 1'b1);
    for (int k = 0; k < 200; k++) tick();
    chk(idx[0] == 197, "restart_beats", $sformatf("got %0d want 197", idx[0]));

    for (int k = 0; k < tab.size(); k++)
      chk(tab[k].seen && tab[k].ga == tab[k].ea && tab[k].gw == tab[k].ew,
          $sformatf("probe_u%0d_m%0d_(%0d,%0d)_d%0d", tab[k].u, tab[k].m, tab[k].h, tab[k].v, tab[k].d),
          $sformatf("got seen %0d addr %0d wall %0d want 1 %0d %0d",
          tab[k].seen, tab[k].ga, tab[k].gw, tab[k].ea, tab[k].ew));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
